game_timer: RTL and testbench
=============================

// Module: game_timer
// PURPOSE
//  Round countdown timer for whack-a-mole. Sits directly downstream of clock_divider.
//  Consumes its clk_1hz output and counts a round down from GAME_SECONDS to 0.
//  Presents the remaining time as two BCD digits for the seven-segment scan logic.
//  Also outputs run, warn and end-of-round flags for the game FSM.
// PARAMETERS
//  GAME_SECONDS  60  round length in seconds; legal 1..99 (elaboration-time $error outside range)
//  WARN_SECONDS  10  warn asserts while remaining time <= this value; legal 0..GAME_SECONDS
// PORTS
//  clk         in   1  system clock (same clock that drives clock_divider)
//  rst         in   1  asynchronous, active-high reset
//  tick_1hz_in in   1  clk_1hz from clock_divider; a level, synchronous to clk
//  start       in   1  start/restart round; sampled per cycle, level or pulse
//  pause       in   1  level; while 1, the countdown is frozen
//  secs_tens   out  4  BCD tens digit of remaining seconds (0..9)
//  secs_ones   out  4  BCD ones digit of remaining seconds (0..9)
//  running     out  1  1 in RUN state only
//  warn        out  1  1 in RUN/PAUSED when 0 < remaining <= WARN_SECONDS
//  time_up     out  1  one-clk pulse when remaining reaches 0
//  game_over   out  1  level, 1 in DONE state
// BEHAVIOUR
//  Reset (async assert, all registers):
//   - state=IDLE, digits=BCD(GAME_SECONDS), tick_d=1.
//   - running, warn, time_up and game_over all =0.
//   - tick_d resetting to 1 suppresses a false edge if tick_1hz_in is already high.
//  Edge detect:
//   - tick_d <= tick_1hz_in every cycle.
//   - sec_edge = tick_1hz_in & ~tick_d (combinational).
//  Latency: digits update on the same clk edge at which sec_edge is true, i.e. 1 clk after the input rises.
//  FSM states IDLE, RUN, PAUSED, DONE. All outputs are registered.
//   - IDLE:   digits hold BCD(GAME_SECONDS). start -> RUN (reload digits).
//   - RUN:    start -> reload digits, stay RUN.
//             else pause -> PAUSED (no decrement this cycle, even if sec_edge).
//             else sec_edge -> decrement.
//   - PAUSED: start -> reload, RUN. else !pause -> RUN. sec_edge ignored; edges while paused are lost.
//   - DONE:   digits=0, game_over=1. start -> reload, RUN. pause has no effect.
//  Priority, highest first: rst > start > pause > sec_edge.
//  BCD decrement:
//   - ones!=0: ones-1.
//   - ones==0: ones=9, tens-1.
//   - Never decrements below 00.
//  Expiry:
//   - The decrement from 01 to 00 also moves the state to DONE.
//   - time_up is 1 for exactly that one clk; game_over is set on the same edge.
//  warn is registered from next-state and next-digits, so it changes on the same edge as the digits.
//   - warn=0 in IDLE and DONE; warn=0 whenever WARN_SECONDS=0.
//  running, warn, game_over and time_up all clear on the edge that enters IDLE or performs a reload.
//   - Exception: the reload sets running=1.
//  Async reset mid-round: outputs go to reset values immediately. No time_up is generated.
// TESTING (GAME_SECONDS=5, WARN_SECONDS=2; tick_1hz_in driven by the bench as a square wave, 20 clk period)
//  1 Reset with tick_1hz_in=1, then release:
//    -> no decrement until the next rising edge of tick_1hz_in.
//    -> state IDLE, digits 0/5, all flags 0.
//  2 Pulse start, run 5 tick edges:
//    -> digits step 5,4,3,2,1,0, each 1 clk after an input edge.
//    -> warn=1 at 2 and at 1.
//    -> time_up=1 for one clk at 0; game_over stays 1; running=0.
//  3 Hold pause=1 across 3 tick edges at count 4:
//    -> digits stay 4, running=0.
//    -> after pause drops, the next edge gives 3.
//  4 start and sec_edge in the same cycle at count 3:
//    -> digits reload to 5, no decrement; running stays 1.
//  5 GAME_SECONDS=12, run to 10 -> 09:
//    -> tens 1->0 and ones 0->9 on one edge; no spurious time_up.
//  6 Assert rst at count 2 mid-round:
//    -> immediate IDLE, digits 0/5, warn=0, time_up never pulses.
//  7 start in DONE:
//    -> digits 5, running=1, game_over=0 on the next edge.

Source files
------------

// File: rtl/game_timer_if.sv
// Control/status bundle between the game FSM side (master) and the round timer (slave).
// The master drives the 1 Hz tick, start and pause; the timer returns the BCD digits and the round flags.
interface game_timer_if;
    logic       tick_1hz_in;
    logic       start;
    logic       pause;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       running;
    logic       warn;
    logic       time_up;
    logic       game_over;

    modport master (
        output tick_1hz_in, start, pause,
        input  secs_tens, secs_ones, running, warn, time_up, game_over
    );

    modport slave (
        input  tick_1hz_in, start, pause,
        output secs_tens, secs_ones, running, warn, time_up, game_over
    );
endinterface

// File: rtl/game_timer.sv
// Whack-a-mole round timer: counts GAME_SECONDS down to 0 in BCD, one step per rising edge of the 1 Hz level.
// Provides registered running/warn/time_up/game_over flags for the game FSM.
module game_timer #(
    parameter int GAME_SECONDS = 60,
    parameter int WARN_SECONDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    game_timer_if.slave  bus
);

    if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_game_seconds
        $error("game_timer: GAME_SECONDS must be in 1..99");
    end
    if (WARN_SECONDS < 0 || WARN_SECONDS > GAME_SECONDS) begin : g_bad_warn_seconds
        $error("game_timer: WARN_SECONDS must be in 0..GAME_SECONDS");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [3:0] INIT_TENS  = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] INIT_ONES  = 4'(GAME_SECONDS % 10);
    localparam logic [6:0] WARN_LIMIT = 7'(WARN_SECONDS);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       tick_q;
    logic       running_q, running_d;
    logic       warn_q, warn_d;
    logic       time_up_q, time_up_d;
    logic       game_over_q, game_over_d;
    logic       sec_edge;
    logic [6:0] remaining_d;

    always_comb begin
        sec_edge    = bus.tick_1hz_in & ~tick_q;
        state_d     = state_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        time_up_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                tens_d = INIT_TENS;
                ones_d = INIT_ONES;
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.start) begin
                    tens_d = INIT_TENS;
                    ones_d = INIT_ONES;
                end else if (bus.pause) begin
                    state_d = PAUSED;
                end else if (sec_edge) begin
                    // Borrow from tens when ones is 0; 00 is never decremented.
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else if (tens_q != 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                    if (tens_q == 4'd0 && ones_q == 4'd1) begin
                        state_d   = DONE;
                        time_up_d = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (bus.start) begin
                    tens_d  = INIT_TENS;
                    ones_d  = INIT_ONES;
                    state_d = RUN;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                tens_d = 4'd0;
                ones_d = 4'd0;
                if (bus.start) begin
                    tens_d  = INIT_TENS;
                    ones_d  = INIT_ONES;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                tens_d  = INIT_TENS;
                ones_d  = INIT_ONES;
            end
        endcase

        // Flags follow next-state/next-digits so they move on the same edge as the display.
        remaining_d = ({3'd0, tens_d} * 7'd10) + {3'd0, ones_d};
        running_d   = (state_d == RUN);
        game_over_d = (state_d == DONE);
        warn_d      = ((state_d == RUN) || (state_d == PAUSED)) &&
                      (remaining_d != 7'd0) && (remaining_d <= WARN_LIMIT);
    end

    // tick_q resets high so a tick already high at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tens_q      <= INIT_TENS;
            ones_q      <= INIT_ONES;
            tick_q      <= 1'b1;
            running_q   <= 1'b0;
            warn_q      <= 1'b0;
            time_up_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            tick_q      <= bus.tick_1hz_in;
            running_q   <= running_d;
            warn_q      <= warn_d;
            time_up_q   <= time_up_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.secs_tens = tens_q;
    assign bus.secs_ones = ones_q;
    assign bus.running   = running_q;
    assign bus.warn      = warn_q;
    assign bus.time_up   = time_up_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: table vectors on a 5 s / warn 2 instance, directed corner sequences,
// and random stimulus on both a 5 s and a 12 s instance checked against a seconds-level model.
module tb_game_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic tick = 1'b1;

    always #5 clk = ~clk;

    game_timer_if bus_a ();
    game_timer_if bus_b ();

    assign bus_a.start = start;
    assign bus_a.pause = pause;
    assign bus_a.tick_1hz_in = tick;
    assign bus_b.start = start;
    assign bus_b.pause = pause;
    assign bus_b.tick_1hz_in = tick;

    game_timer #(.GAME_SECONDS(5),  .WARN_SECONDS(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    game_timer #(.GAME_SECONDS(12), .WARN_SECONDS(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: remaining seconds as an integer plus round status bits.
    int GS[2] = '{5, 12};
    int WS[2] = '{2, 2};
    int m_rem[2];
    bit m_in_round[2], m_frozen[2], m_finished[2], m_tu[2];
    bit m_prev_tick;

    bit tick_auto = 1'b0;
    int phase = 0;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = GS[k];
            m_in_round[k] = 1'b0;
            m_frozen[k] = 1'b0;
            m_finished[k] = 1'b0;
            m_tu[k] = 1'b0;
        end
        m_prev_tick = 1'b1;
    endfunction

    function automatic void model_step();
        bit edge_seen;
        edge_seen = tick && !m_prev_tick;
        m_prev_tick = tick;
        for (int k = 0; k < 2; k++) begin
            m_tu[k] = 1'b0;
            if (start) begin
                m_rem[k] = GS[k];
                m_in_round[k] = 1'b1;
                m_frozen[k] = 1'b0;
                m_finished[k] = 1'b0;
            end else if (m_in_round[k] && m_frozen[k]) begin
                if (!pause) m_frozen[k] = 1'b0;
            end else if (m_in_round[k]) begin
                if (pause) begin
                    m_frozen[k] = 1'b1;
                end else if (edge_seen && m_rem[k] > 0) begin
                    m_rem[k] = m_rem[k] - 1;
                    if (m_rem[k] == 0) begin
                        m_in_round[k] = 1'b0;
                        m_finished[k] = 1'b1;
                        m_tu[k] = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [11:0] model_out(int k);
        logic [3:0] t, o;
        logic r, w;
        t = 4'(m_rem[k] / 10);
        o = 4'(m_rem[k] % 10);
        r = m_in_round[k] && !m_frozen[k];
        w = m_in_round[k] && (m_rem[k] > 0) && (m_rem[k] <= WS[k]);
        return {t, o, r, w, m_tu[k], m_finished[k]};
    endfunction

    function automatic logic [11:0] dut_out(int k);
        if (k == 0)
            return {bus_a.secs_tens, bus_a.secs_ones, bus_a.running, bus_a.warn, bus_a.time_up, bus_a.game_over};
        else
            return {bus_b.secs_tens, bus_b.secs_ones, bus_b.running, bus_b.warn, bus_b.time_up, bus_b.game_over};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got digits=%h%h run=%b warn=%b tu=%b go=%b, expected digits=%h%h run=%b warn=%b tu=%b go=%b",
                     name, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One clock: advance the tick square wave if enabled, take the edge, step the model, settle.
    task automatic cyc();
        if (tick_auto) begin
            phase = (phase + 1) % 20;
            tick = (phase < 10);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        pause = 1'b0;
        tick = 1'b1;
        phase = 0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_a", dut_out(0), model_out(0));
        chk("reset_b", dut_out(1), model_out(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic start, pause, tick;
        logic [3:0] tens, ones;
        logic running, warn, time_up, game_over;
    } vec_t;

    vec_t vecs[$];

    function automatic void mk(logic s, logic p, logic t, logic [3:0] te, logic [3:0] on,
                               logic r, logic w, logic tu, logic go);
        vec_t v;
        v.start = s; v.pause = p; v.tick = t;
        v.tens = te; v.ones = on;
        v.running = r; v.warn = w; v.time_up = tu; v.game_over = go;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int prev_b;

        // Hand-derived expectations for the 5 s / warn 2 instance.
        //  st pa tk  tens ones  run warn tu go
        mk(0, 0, 1, 0, 5, 0, 0, 0, 0);  // idle after reset, tick already high
        mk(0, 0, 0, 0, 5, 0, 0, 0, 0);
        mk(1, 0, 1, 0, 5, 1, 0, 0, 0);  // start wins over the edge
        mk(0, 0, 0, 0, 5, 1, 0, 0, 0);
        mk(0, 0, 1, 0, 4, 1, 0, 0, 0);
        mk(0, 0, 1, 0, 4, 1, 0, 0, 0);  // level high, no second edge
        mk(0, 1, 0, 0, 4, 0, 0, 0, 0);
        mk(0, 1, 1, 0, 4, 0, 0, 0, 0);  // edge lost while paused
        mk(0, 0, 0, 0, 4, 1, 0, 0, 0);
        mk(0, 0, 1, 0, 3, 1, 0, 0, 0);
        mk(0, 0, 0, 0, 3, 1, 0, 0, 0);
        mk(0, 0, 1, 0, 2, 1, 1, 0, 0);
        mk(0, 0, 0, 0, 2, 1, 1, 0, 0);
        mk(0, 1, 0, 0, 2, 0, 1, 0, 0);
        mk(0, 0, 1, 0, 2, 1, 1, 0, 0);  // unpause on an edge: no decrement
        mk(0, 0, 0, 0, 2, 1, 1, 0, 0);
        mk(0, 0, 1, 0, 1, 1, 1, 0, 0);
        mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        mk(0, 0, 1, 0, 0, 0, 0, 1, 1);  // expiry
        mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        mk(0, 1, 1, 0, 0, 0, 0, 0, 1);  // pause ignored in done
        mk(1, 0, 0, 0, 5, 1, 0, 0, 0);  // restart from done
        mk(1, 0, 1, 0, 5, 1, 0, 0, 0);
        mk(0, 0, 0, 0, 5, 1, 0, 0, 0);
        mk(0, 0, 1, 0, 4, 1, 0, 0, 0);
        mk(0, 0, 0, 0, 4, 1, 0, 0, 0);
        mk(0, 0, 1, 0, 3, 1, 0, 0, 0);
        mk(0, 0, 0, 0, 3, 1, 0, 0, 0);
        mk(1, 0, 1, 0, 5, 1, 0, 0, 0);  // start with edge at 3: reload, no decrement
        mk(0, 0, 0, 0, 5, 1, 0, 0, 0);

        @(posedge clk);
        do_reset();
        tick_auto = 1'b0;
        foreach (vecs[i]) begin
            start = vecs[i].start;
            pause = vecs[i].pause;
            tick = vecs[i].tick;
            cyc();
            chk($sformatf("vec%0d", i), dut_out(0),
                {vecs[i].tens, vecs[i].ones, vecs[i].running, vecs[i].warn, vecs[i].time_up, vecs[i].game_over});
            chk($sformatf("vec%0d_b_model", i), dut_out(1), model_out(1));
            $display("vec %0d: start=%b pause=%b tick=%b -> %h%h run=%b warn=%b tu=%b go=%b",
                     i, start, pause, tick, bus_a.secs_tens, bus_a.secs_ones,
                     bus_a.running, bus_a.warn, bus_a.time_up, bus_a.game_over);
        end

        // 12 s instance: the 10 -> 09 borrow must happen on one edge with no time_up.
        do_reset();
        tick_auto = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            prev_b = m_rem[1];
            cyc();
            chk("borrow_run_b", dut_out(1), model_out(1));
            if (prev_b == 10 && m_rem[1] == 9) begin
                seen = 1'b1;
                chk("b_10_to_09", dut_out(1), {4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0});
            end
        end
        if (!seen) chk("b_10_to_09_timeout", 12'h000, 12'h001);
        $display("seq borrow: b digits=%h%h tu=%b", bus_b.secs_tens, bus_b.secs_ones, bus_b.time_up);

        // Async reset in mid-round at count 2 on the 5 s instance.
        do_reset();
        tick_auto = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            cyc();
            if (m_rem[0] == 2) seen = 1'b1;
        end
        if (!seen) chk("count2_timeout", 12'h000, 12'h001);
        chk("at_count2", dut_out(0), {4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midround_reset_now", dut_out(0), {4'd0, 4'd5, 4'b0000});
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", dut_out(0), {4'd0, 4'd5, 4'b0000});
        end
        rst = 1'b0;
        $display("seq midreset: a digits=%h%h warn=%b tu=%b", bus_a.secs_tens, bus_a.secs_ones, bus_a.warn, bus_a.time_up);

        // Random start/pause over the running square wave, both instances against the model.
        do_reset();
        tick_auto = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) pause = ~pause;
            cyc();
            chk("rand_a", dut_out(0), model_out(0));
            chk("rand_b", dut_out(1), model_out(1));
        end
        $display("seq random: 3000 cycles applied");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
